// File: rtl/sincos_phase_detect.sv
// sincos_phase_detect: iterative CORDIC vectoring engine.
// Converts a signed I/Q pair into a PH_W-bit phase angle (0 = +I, quarter turn = +Q)
// and an uncompensated magnitude (CORDIC gain ~1.6468 left in).
// One sample in flight at a time, accepted through a valid/ready handshake.
module sincos_phase_detect #(
  parameter int ITERATIONS = 12,
  parameter int IN_W       = 10,
  parameter int PH_W       = 10
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ClkEn,
  input  logic              InValid,
  output logic              InReady,
  input  logic [IN_W-1:0]   I,
  input  logic [IN_W-1:0]   Q,
  output logic              OutValid,
  output logic [PH_W-1:0]   Theta,
  output logic [IN_W+1:0]   Magnitude
);

  // x/y carry 3 bits of growth plus 2 fractional guard bits
  localparam int XW = IN_W + 5;
  // z carries 4 fractional bits below the output LSB
  localparam int ZW = PH_W + 4;
  localparam int MW = IN_W + 2;
  localparam int CW = 4;
  localparam logic [ZW-1:0] HALF_TURN = {1'b1, {(ZW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ROTATE, OUT} state_t;

  state_t               r_state;
  state_t               w_next;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic [ZW-1:0]        r_z;
  logic [CW-1:0]        r_iter;
  logic                 r_zero;
  logic                 r_outvalid;
  logic [PH_W-1:0]      r_theta;
  logic [MW-1:0]        r_mag;

  logic signed [XW-1:0] w_i_ext;
  logic signed [XW-1:0] w_q_ext;
  logic signed [XW-1:0] w_x_sh;
  logic signed [XW-1:0] w_y_sh;
  logic [ZW-1:0]        w_atan;
  logic [PH_W-1:0]      w_theta;
  logic [MW-1:0]        w_mag;

  // atan(2^-i) in units of 2^-14 turn (14-bit z, i.e. PH_W = 10)
  function automatic logic [ZW-1:0] atan_lut(input logic [CW-1:0] idx);
    case (idx)
      4'd0:    atan_lut = ZW'(2048);
      4'd1:    atan_lut = ZW'(1209);
      4'd2:    atan_lut = ZW'(639);
      4'd3:    atan_lut = ZW'(324);
      4'd4:    atan_lut = ZW'(163);
      4'd5:    atan_lut = ZW'(81);
      4'd6:    atan_lut = ZW'(41);
      4'd7:    atan_lut = ZW'(20);
      4'd8:    atan_lut = ZW'(10);
      4'd9:    atan_lut = ZW'(5);
      4'd10:   atan_lut = ZW'(3);
      4'd11:   atan_lut = ZW'(1);
      4'd12:   atan_lut = ZW'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  // Sign-extend and scale inputs by 4 into the guard-bit format
  assign w_i_ext = {{3{I[IN_W-1]}}, I, 2'b00};
  assign w_q_ext = {{3{Q[IN_W-1]}}, Q, 2'b00};
  assign w_x_sh  = r_x >>> r_iter;
  assign w_y_sh  = r_y >>> r_iter;
  assign w_atan  = atan_lut(r_iter);
  // Round-to-nearest on both outputs; z wraps so 1023.5 rounds to 0
  assign w_theta = PH_W'((r_z + ZW'(8)) >> 4);
  assign w_mag   = MW'((r_x + XW'(2)) >>> 2);

  assign InReady   = (r_state == IDLE);
  assign OutValid  = r_outvalid;
  assign Theta     = r_theta;
  assign Magnitude = r_mag;

  // State register; reset wins over the clock enable
  always_ff @(posedge Clock) begin
    if (Reset)      r_state <= IDLE;
    else if (ClkEn) r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (InValid) w_next = ROTATE;
      ROTATE:  if (r_iter == CW'(ITERATIONS - 1)) w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture with left-half-plane fold, micro-rotations, result load
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_outvalid <= 1'b0;
      r_theta    <= '0;
      r_mag      <= '0;
      r_zero     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_iter     <= '0;
    end else if (ClkEn) begin
      r_outvalid <= (r_state == OUT);
      unique case (r_state)
        IDLE: begin
          if (InValid) begin
            r_iter <= '0;
            r_zero <= (I == '0) && (Q == '0);
            if (I[IN_W-1]) begin
              r_x <= -w_i_ext;
              r_y <= -w_q_ext;
              r_z <= HALF_TURN;
            end else begin
              r_x <= w_i_ext;
              r_y <= w_q_ext;
              r_z <= '0;
            end
          end
        end
        ROTATE: begin
          r_iter <= r_iter + CW'(1);
          if (!r_y[XW-1]) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan;
          end
        end
        OUT: begin
          r_theta <= r_zero ? '0 : w_theta;
          r_mag   <= r_zero ? '0 : w_mag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_phase_detect.sv
// Testbench for sincos_phase_detect: directed vector table, NCO loopback sweeps
// with and without clock-enable gaps, held-valid handshake and mid-run reset.
module tb_sincos_phase_detect;

  logic       Clock;
  logic       Reset;
  logic       ClkEn;
  logic       InValid;
  logic       InReady;
  logic [9:0] I;
  logic [9:0] Q;
  logic       OutValid;
  logic [9:0] Theta;
  logic [11:0] Magnitude;

  int n_checks;
  int n_errors;

  typedef struct {
    int i;
    int q;
    int theta;
    int tol;
    int mag_lo;
    int mag_hi;
  } vec_t;

  vec_t vt[11];

  int hs_i[4] = '{511, 0, -512, 0};
  int hs_q[4] = '{0, 511, 0, -512};
  int hs_t[4] = '{0, 256, 512, 768};

  sincos_phase_detect #(.ITERATIONS(12), .IN_W(10), .PH_W(10)) dut (
    .Clock(Clock), .Reset(Reset), .ClkEn(ClkEn), .InValid(InValid),
    .InReady(InReady), .I(I), .Q(Q), .OutValid(OutValid),
    .Theta(Theta), .Magnitude(Magnitude)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic chk_th(input string name, input int got, input int exp, input int tol);
    int d;
    n_checks++;
    d = ((got - exp + 1536) % 1024) - 512;
    if (d < -tol || d > tol) begin
      n_errors++;
      $display("FAIL %s: got theta %0d, want %0d +/-%0d", name, got, exp, tol);
    end
  endtask

  function automatic void nco(input int k, output int c, output int s);
    real a;
    a = 2.0 * 3.14159265358979 * real'(k) / 1024.0;
    c = int'(511.0 * $cos(a));
    s = int'(511.0 * $sin(a));
  endfunction

  // Starts and ends on a falling edge. lat counts enabled edges from acceptance
  // to the edge on which OutValid rises.
  task automatic do_sample(input int vi, input int vq, input bit rnd_en, input bit chk_pulse,
                           output int th, output int mg, output int lat);
    bit accepted, done, en_edge, will_acc, pdone;
    accepted = 0; done = 0; lat = 0; th = -1; mg = -1;
    I = 10'(vi); Q = 10'(vq); InValid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      ClkEn    = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      en_edge  = ClkEn;
      will_acc = !accepted && ClkEn && InReady;
      @(negedge Clock);
      if (will_acc) begin
        accepted = 1;
        InValid  = 1'b0;
      end else if (accepted && en_edge) begin
        lat++;
        if (OutValid) begin
          done = 1;
          th = int'(Theta);
          mg = int'(Magnitude);
        end
      end
    end
    chk_rng("result_arrived", int'(done), 1, 1);
    if (done && chk_pulse) begin
      pdone = 0;
      for (int n = 0; n < 100 && !pdone; n++) begin
        ClkEn   = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        en_edge = ClkEn;
        @(negedge Clock);
        if (en_edge) begin
          chk_rng("pulse_cleared", int'(OutValid), 0, 0);
          pdone = 1;
        end else begin
          chk_rng("pulse_held", int'(OutValid), 1, 1);
        end
      end
    end
    ClkEn = 1'b1;
  endtask

  initial begin
    int th, mg, lat, c, s;
    int edge_n, last_acc, acc_cnt, res_cnt, acc_ov, cur, idx, ov_seen;
    bit will_acc, ov_pre;

    n_checks = 0; n_errors = 0;
    vt[0]  = '{511,    0,   0, 0,  840,  844};
    vt[1]  = '{0,    511, 256, 0,  840,  844};
    vt[2]  = '{-512,   0, 512, 0,  841,  845};
    vt[3]  = '{0,   -512, 768, 0,  841,  845};
    vt[4]  = '{362, -362, 896, 0,  841,  845};
    vt[5]  = '{0,      0,   0, 0,    0,    0};
    vt[6]  = '{256,  256, 128, 1,  594,  598};
    vt[7]  = '{-300, 400, 361, 1,  821,  826};
    vt[8]  = '{-512,-512, 640, 1, 1190, 1194};
    vt[9]  = '{511,   -1,   0, 1,  840,  844};
    vt[10] = '{-512,   1, 512, 1,  841,  845};

    Reset = 1'b1; ClkEn = 1'b1; InValid = 1'b0; I = '0; Q = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    chk_rng("reset_outvalid", int'(OutValid), 0, 0);
    chk_rng("reset_theta", int'(Theta), 0, 0);
    chk_rng("reset_mag", int'(Magnitude), 0, 0);
    chk_rng("reset_inready", int'(InReady), 1, 1);

    // Directed vectors
    foreach (vt[k]) begin
      do_sample(vt[k].i, vt[k].q, 1'b0, 1'b1, th, mg, lat);
      chk_rng($sformatf("vec%0d_latency", k), lat, 13, 13);
      chk_th($sformatf("vec%0d_theta", k), th, vt[k].theta, vt[k].tol);
      chk_rng($sformatf("vec%0d_mag", k), mg, vt[k].mag_lo, vt[k].mag_hi);
    end

    // Full loopback sweep, enable always high
    for (int k = 0; k < 1024; k++) begin
      nco(k, c, s);
      do_sample(c, s, 1'b0, 1'b0, th, mg, lat);
      chk_th($sformatf("sweep%0d_theta", k), th, k, 1);
      chk_rng($sformatf("sweep%0d_mag", k), mg, 836, 845);
    end

    // Decimated sweep with random clock enable, including the 1023 wrap
    for (int k = 0; k < 1024; k += 7) begin
      nco(k, c, s);
      do_sample(c, s, 1'b1, 1'b1, th, mg, lat);
      chk_rng($sformatf("rnd%0d_latency", k), lat, 13, 13);
      chk_th($sformatf("rnd%0d_theta", k), th, k, 1);
      chk_rng($sformatf("rnd%0d_mag", k), mg, 836, 845);
    end
    nco(1023, c, s);
    do_sample(c, s, 1'b1, 1'b1, th, mg, lat);
    chk_th("rnd1023_theta", th, 1023, 1);

    // InValid held high: inputs change while busy and must be ignored
    ClkEn = 1'b1; InValid = 1'b1; idx = 0; cur = 0;
    I = 10'(hs_i[0]); Q = 10'(hs_q[0]);
    edge_n = 0; last_acc = -100; acc_cnt = 0; res_cnt = 0; acc_ov = 0;
    for (int n = 0; n < 60; n++) begin
      will_acc = InReady;
      ov_pre   = OutValid;
      @(negedge Clock);
      edge_n++;
      if (OutValid) begin
        res_cnt++;
        chk_rng("held_latency", edge_n - last_acc, 13, 13);
        chk_th("held_theta", int'(Theta), hs_t[cur], 0);
      end
      if (will_acc) begin
        acc_cnt++;
        last_acc = edge_n;
        cur = idx % 4;
        if (ov_pre) acc_ov++;
        idx++;
        I = 10'(hs_i[idx % 4]);
        Q = 10'(hs_q[idx % 4]);
      end
    end
    chk_rng("held_results", res_cnt, 4, 4);
    chk_rng("held_accepts", acc_cnt, 5, 5);
    chk_rng("held_b2b_accepts", acc_ov, 4, 4);
    InValid = 1'b0;
    repeat (20) @(negedge Clock);

    // Reset in the middle of a rotation
    I = 10'(511); Q = 10'(0); InValid = 1'b1; ClkEn = 1'b1;
    @(negedge Clock);
    chk_rng("midrst_busy", int'(InReady), 0, 0);
    InValid = 1'b0;
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk_rng("midrst_inready", int'(InReady), 1, 1);
    chk_rng("midrst_outvalid", int'(OutValid), 0, 0);
    chk_rng("midrst_theta", int'(Theta), 0, 0);
    chk_rng("midrst_mag", int'(Magnitude), 0, 0);
    ov_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clock);
      if (OutValid) ov_seen++;
    end
    chk_rng("midrst_no_result", ov_seen, 0, 0);
    do_sample(0, 511, 1'b0, 1'b1, th, mg, lat);
    chk_rng("midrst_next_latency", lat, 13, 13);
    chk_th("midrst_next_theta", th, 256, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sincos_phase_detect.md
# sincos_phase_detect

Iterative CORDIC vectoring engine that converts a signed I/Q sample pair back into a 10-bit phase angle and an uncompensated magnitude. It inverts the NCO sine/cosine generator in the SDR peripheral: Cosine maps to I, Sine maps to Q, and Theta uses the same 0–1023 = 0–2π convention. The block serves phase measurement, PLL phase error and FM demodulation in the receive path. It is a single-issue engine with a valid/ready handshake on its input.

## Interface
- ITERATIONS, 12: CORDIC micro-rotations, legal range 8–14.
- IN_W, 10: I/Q width, two's complement.
- PH_W, 10: Theta width. Full turn = 2^PH_W.

- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- ClkEn  in  1  clock enable; all state advances only on edges with ClkEn=1
- InValid  in  1  I/Q pair presented
- InReady  out  1  high only in IDLE (combinational from state)
- I  in  IN_W  signed in-phase (cosine) sample
- Q  in  IN_W  signed quadrature (sine) sample
- OutValid  out  1  result pulse, one enabled cycle
- Theta  out  PH_W  angle; 0 = +I axis, 256 = +Q axis
- Magnitude  out  IN_W+2  unsigned, equals |(I,Q)| × 1.6468 (CORDIC gain not removed)

## Operation
- State machine has three states: IDLE, ROTATE, OUT.
- IDLE: InReady=1. On an enabled edge with InValid=1, capture the sample and go to ROTATE with the iteration counter at 0.
- Pre-fold at capture:
  - If I<0: x=-I, y=-Q, z=half turn.
  - Otherwise: x=I, y=Q, z=0.
  - -(-512) must be representable.
- Zero flag: set at capture when I=0 and Q=0.
- Internal widths:
  - x and y are signed IN_W+5: 3 bits of growth plus 2 fractional guard bits. Inputs are left-shifted by 2.
  - z is PH_W+4 bits and wraps modulo 2^(PH_W+4).
- ROTATE, one iteration i per enabled edge:
  - If y≥0: x+=y>>>i, y-=x>>>i, z+=A[i].
  - If y<0: x-=y>>>i, y+=x>>>i, z-=A[i].
  - Both updates use the old x and y values.
  - A[i] = round(atan(2^-i)·2^(PH_W+4)/2π), held in a constant table.
  - After iteration ITERATIONS-1, go to OUT.
- OUT, on a single enabled edge:
  - Theta = ((z+8)>>4) mod 2^PH_W. Rounding up from 1023.5 wraps to 0.
  - Magnitude = (x+2)>>2.
  - If the zero flag is set, Theta=0 and Magnitude=0.
  - Assert OutValid and return to IDLE.
- Theta and Magnitude hold until the next result.
- Reset from any state: state=IDLE, OutValid=0, Theta=0, Magnitude=0, zero flag cleared. Any in-flight sample is discarded with no OutValid.
- InValid while busy is ignored. There is no queueing; the upstream block must hold InValid until InReady.
- Accuracy: Theta within ±1 LSB (mod 2^PH_W) of ideal atan2(Q,I) whenever |(I,Q)| ≥ 128.

## Timing
- Acceptance edge is N.
- ROTATE occupies enabled edges N+1 … N+ITERATIONS.
- Edge N+ITERATIONS+1 loads the outputs. OutValid is high from that edge until the next enabled edge.
- Latency is ITERATIONS+1 enabled edges, 13 by default.
- InReady is high in the same cycle OutValid is high, so a new sample can be accepted on the edge that clears OutValid.
- Throughput is one sample per ITERATIONS+1 enabled edges.
- With ClkEn=0 every register holds, including OutValid. Latency is counted in enabled edges only.

## Test plan
- Reset: assert Reset for 2 cycles. Expect OutValid=0, Theta=0, Magnitude=0, InReady=1.
- Cardinal points, each checked against ideal values:
  - (511,0) gives Theta=0, Magnitude=842±2.
  - (0,511) gives 256.
  - (-512,0) gives 512.
  - (0,-512) gives 768.
  - (362,-362) gives 896, Magnitude=843±2.
  - OutValid rises exactly 13 enabled edges after acceptance in every case.
- Zero vector: input (0,0). Expect Theta=0, Magnitude=0, OutValid pulse still produced.
- Loopback sweep: drive the NCO sine/cosine generator with Theta 0…1023 and feed Cosine→I, Sine→Q. Recovered Theta must equal the input within ±1 LSB mod 1024, including 1023→0 wrap. Magnitude must stay within 836–845.
- Handshake and enable:
  - With ClkEn randomly 50%, results match the sweep and OutValid lasts one enabled cycle.
  - InValid held high while busy gives exactly one result per 13 enabled edges.
  - A back-to-back accept in the OutValid cycle works.
- Reset mid-operation: assert Reset at iteration 5. Expect IDLE and InReady=1 next cycle, no OutValid. The next sample (0,511) gives Theta=256.
